nv_nvdla_glb_csb_req_pipe: RTL and testbench
============================================

// Module: nv_nvdla_glb_csb_req_pipe
// PURPOSE
//  Upstream stage of the GLB CSB responder: buffers CSB requests (63b csb2xx_16m_be_lvl pkt) in a small
//  FIFO, meters non-posted issue against an outstanding-response budget, and re-registers the responder's
//  34b nvdla_xx2csb_resp back toward CSB. Isolates the responder from CSB backpressure and timing.
// PARAMETERS
//  DEPTH       4   request FIFO entries; power of 2, >=2
//  MAX_OUTST   2   max non-posted requests issued without a returned response; 1..15
// PORTS
//  nvdla_core_clk       in   1   core clock; single clock domain
//  nvdla_core_rstn      in   1   asynchronous active-low reset
//  csb2glb_req_pvld     in   1   upstream request valid
//  csb2glb_req_prdy     out  1   upstream ready (=!full)
//  csb2glb_req_pd       in   63  request pkt: addr[21:0] wdat[53:22] write[54] nposted[55] srcpriv[56] wrbe[60:57] level[62:61]
//  csb2gec_req_pvld     out  1   request valid to responder
//  csb2gec_req_prdy     in   1   responder ready
//  csb2gec_req_pd       out  63  FIFO head pkt, unmodified
//  gec2csb_resp_valid   in   1   response from responder
//  gec2csb_resp_pd      in   34  rdat[31:0] error[32] is_wr[33]
//  glb2csb_resp_valid   out  1   registered response valid to CSB
//  glb2csb_resp_pd      out  34  registered response pkt
//  req_occupancy        out  $clog2(DEPTH)+1  FIFO entry count
//  outst_cnt            out  4   non-posted requests awaiting response
//  resp_unexpected      out  1   sticky: response arrived with outst_cnt==0
// BEHAVIOUR
//  Reset (async, rstn low): FIFO empty, rd/wr ptrs 0, occupancy 0, outst_cnt 0, prdy 0 while in reset then 1,
//   csb2gec_req_pvld 0, csb2gec_req_pd 0, glb2csb_resp_valid 0, glb2csb_resp_pd 0, resp_unexpected 0.
//   Reset mid-operation discards all buffered requests and outstanding credit.
//  Push: csb2glb_req_pvld & csb2glb_req_prdy. prdy = !full; no dependence on csb2gec_req_prdy (no comb path).
//  Storage registered; no bypass: pkt pushed in cycle N is earliest visible at csb2gec_req_* in cycle N+1.
//  Head non-posted: np = ~write | (write & nposted). Posted writes never consume credit.
//  csb2gec_req_pvld = !empty & (!np | outst_cnt < MAX_OUTST). Pop = pvld & csb2gec_req_prdy.
//  Once pvld asserted, pd holds stable until pop (head not advanced; credit only grows while waiting).
//  outst_cnt: +1 on pop of np head, -1 on gec2csb_resp_valid; both same cycle -> unchanged.
//   resp with outst_cnt==0 -> counter stays 0 (no wrap), resp_unexpected set until reset.
//  Full: push blocked; simultaneous pop & push when not full -> occupancy unchanged. Ptrs wrap mod DEPTH.
//  Empty & push same cycle: pvld stays 0 that cycle (no bypass).
//  Response path: glb2csb_resp_valid <= gec2csb_resp_valid every cycle; glb2csb_resp_pd loads only when
//   gec2csb_resp_valid, else holds. Latency exactly 1 cycle; no backpressure (CSB response has no ready).
//  Responder answers 1 cycle after accept, so MAX_OUTST=2 sustains 1 np req/cycle once pipeline is primed.
// STRUCTURE
//  Package nv_nvdla_glb_csb_pkg: REQ_PD_W=63, RESP_PD_W=34, field LSB/width constants for addr, wdat,
//   write, nposted, srcpriv, wrbe, level; resp rdat/error/is_wr positions; RESP_ID_RD=0, RESP_ID_WR=1.
//  Sub-module nv_nvdla_glb_csb_fifo (DEPTH, WIDTH): flop-array FIFO, push/pop/full/empty/count.
//  Top holds credit counter, issue gating, sticky error, response register.
// TESTING
//  Reset, push 1 read (write=0) with csb2gec_req_prdy=1 -> pvld at cycle+1, outst_cnt 0->1, resp 1 cyc later
//   -> glb2csb_resp_valid 1 cycle after, pd[33]=0, outst_cnt back to 0.
//  csb2gec_req_prdy=0, push 5 pkts with DEPTH=4 -> 4 accepted, prdy=0 on 5th, occupancy=4; release -> 4 pops in order.
//  MAX_OUTST=2, 3 back-to-back reads, responses withheld -> 2 issued, 3rd holds pvld=0 with outst_cnt=2;
//   one resp -> 3rd issues next cycle.
//  Posted writes (write=1,nposted=0) x4 with outst_cnt=2 -> all issue, outst_cnt stays 2.
//  gec2csb_resp_valid with outst_cnt=0 -> resp_unexpected=1 sticky, outst_cnt=0; pop-np + resp same cycle -> unchanged.
//  Assert rstn low with 3 queued and outst_cnt=1 -> all outputs at reset values immediately; no stale pkt after release.

Source files
------------

// File: rtl/nv_nvdla_glb_csb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_glb_csb_pkg
//  Description : Shared widths, packet field positions and helpers for the
//                GLB CSB request pipe.
//  Revision    : 1.0
// ============================================================================
package nv_nvdla_glb_csb_pkg;

  localparam int REQ_PD_W       = 63;
  localparam int RESP_PD_W      = 34;

  localparam int REQ_ADDR_LSB   = 0;
  localparam int REQ_ADDR_W     = 22;
  localparam int REQ_WDAT_LSB   = 22;
  localparam int REQ_WDAT_W     = 32;
  localparam int REQ_WRITE_BIT  = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int REQ_SRCPRIV_BIT = 56;
  localparam int REQ_WRBE_LSB   = 57;
  localparam int REQ_WRBE_W     = 4;
  localparam int REQ_LEVEL_LSB  = 61;
  localparam int REQ_LEVEL_W    = 2;

  localparam int RESP_RDAT_LSB  = 0;
  localparam int RESP_RDAT_W    = 32;
  localparam int RESP_ERROR_BIT = 32;
  localparam int RESP_IS_WR_BIT = 33;

  localparam logic RESP_ID_RD   = 1'b0;
  localparam logic RESP_ID_WR   = 1'b1;

  // Reads and non-posted writes both expect a response and so consume credit.
  function automatic logic req_is_nonposted(input logic [REQ_PD_W-1:0] pd);
    return ~pd[REQ_WRITE_BIT] | pd[REQ_NPOSTED_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_glb_csb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_glb_csb_fifo
//  Description : Flop-array FIFO with registered storage and no bypass path.
//  Revision    : 1.0
// ============================================================================
module nv_nvdla_glb_csb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 63
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == C_FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_mem[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nv_nvdla_glb_csb_req_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_glb_csb_req_pipe
//  Description : CSB request buffer with outstanding-response credit metering
//                and a registered response return path.
//  Revision    : 1.0
// ============================================================================
module nv_nvdla_glb_csb_req_pipe
  import nv_nvdla_glb_csb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     csb2glb_req_pvld,
  output logic                     csb2glb_req_prdy,
  input  logic [REQ_PD_W-1:0]      csb2glb_req_pd,
  output logic                     csb2gec_req_pvld,
  input  logic                     csb2gec_req_prdy,
  output logic [REQ_PD_W-1:0]      csb2gec_req_pd,
  input  logic                     gec2csb_resp_valid,
  input  logic [RESP_PD_W-1:0]     gec2csb_resp_pd,
  output logic                     glb2csb_resp_valid,
  output logic [RESP_PD_W-1:0]     glb2csb_resp_pd,
  output logic [$clog2(DEPTH):0]   req_occupancy,
  output logic [3:0]               outst_cnt,
  output logic                     resp_unexpected
);

  localparam logic [3:0] C_MAX_OUTST = 4'(MAX_OUTST);

  logic                  r_alive;
  logic [3:0]            r_outst;
  logic                  r_unexp;
  logic                  r_resp_valid;
  logic [RESP_PD_W-1:0]  r_resp_pd;

  logic                  w_full;
  logic                  w_empty;
  logic [REQ_PD_W-1:0]   w_head;
  logic                  w_head_np;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue_np;

  nv_nvdla_glb_csb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_PD_W)
  ) u_fifo (
    .clk         (nvdla_core_clk),
    .rst_n       (nvdla_core_rstn),
    .i_push      (w_push),
    .i_push_data (csb2glb_req_pd),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (req_occupancy)
  );

  // Ready stays low until the first clock after reset release.
  assign csb2glb_req_prdy = r_alive & ~w_full;
  assign w_push           = csb2glb_req_pvld & csb2glb_req_prdy;

  assign w_head_np        = req_is_nonposted(w_head);
  assign csb2gec_req_pvld = ~w_empty & (~w_head_np | (r_outst < C_MAX_OUTST));
  assign csb2gec_req_pd   = w_head;
  assign w_pop            = csb2gec_req_pvld & csb2gec_req_prdy;
  assign w_issue_np       = w_pop & w_head_np;

  assign outst_cnt          = r_outst;
  assign resp_unexpected    = r_unexp;
  assign glb2csb_resp_valid = r_resp_valid;
  assign glb2csb_resp_pd    = r_resp_pd;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // A stray response at zero credit saturates rather than wrapping.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_outst <= '0;
      r_unexp <= 1'b0;
    end else begin
      if (w_issue_np && !gec2csb_resp_valid) begin
        r_outst <= r_outst + 1'b1;
      end else if (!w_issue_np && gec2csb_resp_valid && (r_outst != '0)) begin
        r_outst <= r_outst - 1'b1;
      end
      if (gec2csb_resp_valid && (r_outst == '0)) begin
        r_unexp <= 1'b1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_pd    <= '0;
    end else begin
      r_resp_valid <= gec2csb_resp_valid;
      if (gec2csb_resp_valid) begin
        r_resp_pd <= gec2csb_resp_pd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_glb_csb_req_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nv_nvdla_glb_csb_req_pipe
//  Description : Randomized scoreboard bench for the GLB CSB request pipe.
//  Revision    : 1.0
// ============================================================================
module tb_nv_nvdla_glb_csb_req_pipe;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          req_pvld  = 1'b0;
  logic          req_prdy;
  logic [62:0]   req_pd    = '0;
  logic          gec_pvld;
  logic          gec_prdy  = 1'b0;
  logic [62:0]   gec_pd;
  logic          rsp_in_v  = 1'b0;
  logic [33:0]   rsp_in_pd = '0;
  logic          rsp_out_v;
  logic [33:0]   rsp_out_pd;
  logic [CW-1:0] occ;
  logic [3:0]    outst;
  logic          unexp;

  always #5 clk = ~clk;

  nv_nvdla_glb_csb_req_pipe #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .csb2glb_req_pvld   (req_pvld),
    .csb2glb_req_prdy   (req_prdy),
    .csb2glb_req_pd     (req_pd),
    .csb2gec_req_pvld   (gec_pvld),
    .csb2gec_req_prdy   (gec_prdy),
    .csb2gec_req_pd     (gec_pd),
    .gec2csb_resp_valid (rsp_in_v),
    .gec2csb_resp_pd    (rsp_in_pd),
    .glb2csb_resp_valid (rsp_out_v),
    .glb2csb_resp_pd    (rsp_out_pd),
    .req_occupancy      (occ),
    .outst_cnt          (outst),
    .resp_unexpected    (unexp)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of accepted packets plus credit/response state.
  logic [62:0] m_q[$];
  int          m_outst = 0;
  bit          m_unexp = 1'b0;
  bit          m_rdy   = 1'b0;
  bit          m_rvalid = 1'b0;
  logic [33:0] m_rpd   = '0;

  int push_pct = 60;
  int prdy_pct = 70;
  int resp_pct = 50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_np(input logic [62:0] p);
    return (p[54] == 1'b0) || (p[55] == 1'b1);
  endfunction

  always @(negedge clk) begin : monitor
    bit exp_prdy, exp_pvld, push, pop, inc;
    if (!rstn) begin
      m_q.delete();
      m_outst = 0; m_unexp = 0; m_rdy = 0; m_rvalid = 0; m_rpd = '0;
      check("rst_prdy",   64'(req_prdy),   64'(0));
      check("rst_pvld",   64'(gec_pvld),   64'(0));
      check("rst_req_pd", 64'(gec_pd),     64'(0));
      check("rst_rvalid", 64'(rsp_out_v),  64'(0));
      check("rst_rpd",    64'(rsp_out_pd), 64'(0));
      check("rst_occ",    64'(occ),        64'(0));
      check("rst_outst",  64'(outst),      64'(0));
      check("rst_unexp",  64'(unexp),      64'(0));
    end else begin
      exp_prdy = m_rdy && (m_q.size() < DEPTH);
      exp_pvld = (m_q.size() > 0) && (!is_np(m_q[0]) || (m_outst < MAX_OUTST));
      check("prdy",      64'(req_prdy),   64'(exp_prdy));
      check("pvld",      64'(gec_pvld),   64'(exp_pvld));
      check("occupancy", 64'(occ),        64'(m_q.size()));
      check("outst_cnt", 64'(outst),      64'(m_outst));
      check("unexpected",64'(unexp),      64'(m_unexp));
      check("resp_valid",64'(rsp_out_v),  64'(m_rvalid));
      check("resp_pd",   64'(rsp_out_pd), 64'(m_rpd));
      if (exp_pvld) check("req_pd", 64'(gec_pd), 64'(m_q[0]));

      push = req_pvld && exp_prdy;
      pop  = exp_pvld && gec_prdy;
      inc  = 1'b0;
      if (pop) begin
        inc = is_np(m_q[0]);
        void'(m_q.pop_front());
      end
      if (push) m_q.push_back(req_pd);
      if (rsp_in_v && (m_outst == 0)) m_unexp = 1'b1;
      if (inc && !rsp_in_v) m_outst++;
      else if (!inc && rsp_in_v && (m_outst > 0)) m_outst--;
      m_rvalid = rsp_in_v;
      if (rsp_in_v) m_rpd = rsp_in_pd;
      m_rdy = 1'b1;
    end
  end

  task automatic drive();
    logic [63:0] r;
    logic [63:0] s;
    r = {$urandom, $urandom};
    s = {$urandom, $urandom};
    req_pd    = r[62:0];
    req_pvld  = ($urandom_range(0, 99) < push_pct);
    gec_prdy  = ($urandom_range(0, 99) < prdy_pct);
    rsp_in_v  = (m_outst > 0) && ($urandom_range(0, 99) < resp_pct);
    rsp_in_pd = s[33:0];
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      drive();
    end
  endtask

  task automatic drain();
    int i;
    push_pct = 0; prdy_pct = 100; resp_pct = 100;
    i = 0;
    while (i < 200 && !(m_q.size() == 0 && m_outst == 0)) begin
      @(posedge clk); #2;
      drive();
      i++;
    end
    if (!(m_q.size() == 0 && m_outst == 0)) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: queue %0d outst %0d still pending", m_q.size(), m_outst);
    end
    @(posedge clk); #2;
    req_pvld = 1'b0; rsp_in_v = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    push_pct = 60; prdy_pct = 70;  resp_pct = 50; run(1500);
    push_pct = 90; prdy_pct = 10;  resp_pct = 50; run(300);
    push_pct = 80; prdy_pct = 100; resp_pct = 10; run(300);
    push_pct = 70; prdy_pct = 100; resp_pct = 90; run(300);
    drain();

    // Stray response with nothing outstanding.
    @(posedge clk); #2;
    rsp_in_v = 1'b1; rsp_in_pd = 34'h2_DEAD_BEEF;
    @(posedge clk); #2;
    rsp_in_v = 1'b0;
    repeat (5) @(posedge clk);

    // Reset with traffic queued and credit in flight.
    push_pct = 100; prdy_pct = 100; resp_pct = 0; run(2);
    push_pct = 100; prdy_pct = 0;   resp_pct = 0; run(4);
    @(posedge clk); #2;
    rstn = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    push_pct = 60; prdy_pct = 70; resp_pct = 50; run(500);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
